// File: rtl/rv_ctrl_pkg.sv
// Shared control definitions for the RV32I multi-cycle core: opcode map,
// sequencer state encoding and trap cause codes.
package rv_ctrl_pkg;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;

    typedef enum logic [2:0] {
        ST_FETCH,
        ST_DECODE,
        ST_EXEC,
        ST_MEM,
        ST_WB,
        ST_HALT,
        ST_TRAP
    } state_t;

    typedef enum logic [1:0] {
        FC_NONE    = 2'b00,
        FC_ILLEGAL = 2'b01,
        FC_IMEM_TO = 2'b10,
        FC_DMEM_TO = 2'b11
    } fault_t;

    function automatic logic is_legal(input logic [6:0] op);
        case (op)
            OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH,
            OP_LOAD, OP_STORE, OP_IMM, OP_REG: return 1'b1;
            default:                           return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mc_sequencer_if.sv
// Instruction/data memory request handshakes driven by the sequencer.
interface mc_sequencer_if;
    logic imem_req;
    logic imem_ready;
    logic dmem_req;
    logic dmem_we;
    logic dmem_ready;

    modport master (
        output imem_req,
        output dmem_req,
        output dmem_we,
        input  imem_ready,
        input  dmem_ready
    );

    modport slave (
        input  imem_req,
        input  dmem_req,
        input  dmem_we,
        output imem_ready,
        output dmem_ready
    );
endinterface

// File: rtl/mem_wait_timer.sv
// Wait-cycle counter shared by the fetch and data-memory states; flags the
// last permitted stall cycle of a request.
module mem_wait_timer #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clr,
    input  logic i_wait,
    output logic o_limit,
    output logic o_idle
);
    logic [7:0] r_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n || i_clr) begin
            r_cnt <= 8'd0;
        end else if (i_wait) begin
            r_cnt <= r_cnt + 8'd1;
        end
    end

    assign o_limit = (r_cnt == 8'(TIMEOUT - 1));
    assign o_idle  = (r_cnt == 8'd0);
endmodule

// File: rtl/mc_sequencer.sv
// Multi-cycle RV32I sequencer: steps FETCH/DECODE/EXEC/MEM/WB, produces the
// write strobes and memory requests, and traps on illegal opcodes or stalls.
module mc_sequencer
    import rv_ctrl_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [6:0]       opcode,
    input  logic             branch_taken,
    input  logic             halt_req,
    mc_sequencer_if.master   mem,
    output logic             ir_we,
    output logic             mdr_we,
    output logic             rf_we,
    output logic             pc_we,
    output logic             pc_sel,
    output logic             halted,
    output logic             fault,
    output logic [1:0]       fault_code,
    output logic [CNT_W-1:0] instret
);
    state_t             r_state;
    logic               r_fault;
    fault_t             r_code;
    logic [CNT_W-1:0]   r_instret;

    state_t w_next;
    fault_t w_code;
    logic   w_trap, w_retire;
    logic   w_imem_req, w_dmem_req, w_dmem_we;
    logic   w_ir_we, w_mdr_we, w_rf_we, w_pc_we, w_pc_sel;
    logic   w_limit, w_idle, w_wait, w_clr;

    assign w_wait = (w_imem_req && !mem.imem_ready) || (w_dmem_req && !mem.dmem_ready);
    assign w_clr  = (w_next != r_state);

    mem_wait_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_clr   (w_clr),
        .i_wait  (w_wait),
        .o_limit (w_limit),
        .o_idle  (w_idle)
    );

    always_comb begin
        w_next     = r_state;
        w_code     = FC_NONE;
        w_trap     = 1'b0;
        w_retire   = 1'b0;
        w_imem_req = 1'b0;
        w_dmem_req = 1'b0;
        w_dmem_we  = 1'b0;
        w_ir_we    = 1'b0;
        w_mdr_we   = 1'b0;
        w_rf_we    = 1'b0;
        w_pc_we    = 1'b0;
        w_pc_sel   = 1'b0;
        case (r_state)
            ST_FETCH: begin
                // An idle counter marks the entry cycle, before any request is out.
                if (w_idle && halt_req) begin
                    w_next = ST_HALT;
                end else begin
                    w_imem_req = 1'b1;
                    if (mem.imem_ready) begin
                        w_ir_we = 1'b1;
                        w_next  = ST_DECODE;
                    end else if (w_limit) begin
                        w_trap = 1'b1;
                        w_code = FC_IMEM_TO;
                        w_next = ST_TRAP;
                    end
                end
            end
            ST_DECODE: begin
                if (is_legal(opcode)) begin
                    w_next = ST_EXEC;
                end else begin
                    w_trap = 1'b1;
                    w_code = FC_ILLEGAL;
                    w_next = ST_TRAP;
                end
            end
            ST_EXEC: begin
                if (opcode == OP_BRANCH) begin
                    w_pc_we  = 1'b1;
                    w_pc_sel = branch_taken;
                    w_retire = 1'b1;
                    w_next   = ST_FETCH;
                end else if (opcode == OP_LOAD || opcode == OP_STORE) begin
                    w_next = ST_MEM;
                end else begin
                    w_next = ST_WB;
                end
            end
            ST_MEM: begin
                w_dmem_req = 1'b1;
                w_dmem_we  = (opcode == OP_STORE);
                if (mem.dmem_ready) begin
                    if (opcode == OP_STORE) begin
                        w_pc_we  = 1'b1;
                        w_retire = 1'b1;
                        w_next   = ST_FETCH;
                    end else begin
                        w_mdr_we = 1'b1;
                        w_next   = ST_WB;
                    end
                end else if (w_limit) begin
                    w_trap = 1'b1;
                    w_code = FC_DMEM_TO;
                    w_next = ST_TRAP;
                end
            end
            ST_WB: begin
                // PC is written here, after rd has captured the old PC+4 for jumps.
                w_rf_we  = 1'b1;
                w_pc_we  = 1'b1;
                w_pc_sel = (opcode == OP_JAL || opcode == OP_JALR);
                w_retire = 1'b1;
                w_next   = ST_FETCH;
            end
            ST_HALT: begin
                if (!halt_req) w_next = ST_FETCH;
            end
            ST_TRAP: w_next = ST_TRAP;
            default: w_next = ST_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= ST_FETCH;
            r_fault   <= 1'b0;
            r_code    <= FC_NONE;
            r_instret <= '0;
        end else begin
            r_state <= w_next;
            if (w_trap) begin
                r_fault <= 1'b1;
                r_code  <= w_code;
            end
            if (w_retire) r_instret <= r_instret + CNT_W'(1);
        end
    end

    // Strobes and requests are masked while reset is held.
    assign mem.imem_req = rst_n & w_imem_req;
    assign mem.dmem_req = rst_n & w_dmem_req;
    assign mem.dmem_we  = rst_n & w_dmem_we;
    assign ir_we        = rst_n & w_ir_we;
    assign mdr_we       = rst_n & w_mdr_we;
    assign rf_we        = rst_n & w_rf_we;
    assign pc_we        = rst_n & w_pc_we;
    assign pc_sel       = rst_n & w_pc_sel;
    assign halted       = rst_n & (r_state == ST_HALT);
    assign fault        = r_fault;
    assign fault_code   = r_code;
    assign instret      = r_instret;
endmodule
